// File: rtl/fetch_issue.sv
// fetch_issue: PC sequencer with a 1-cycle imem read and a valid/ready issue port.
// Redirects restart fetching at a new PC; an accepted HALT stops it until reset.
module fetch_issue #(
  parameter int         PC_W        = 8,
  parameter int         INSTR_W     = 9,
  parameter logic [3:0] HALT_OPCODE = 4'b1110
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [3:0]         opcode,
  output logic               imm_flag,
  output logic [1:0]         format,
  output logic [INSTR_W-8:0] operand,
  output logic [PC_W-1:0]    issue_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ISSUE,
    S_HALTED
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic            accept;
  logic            is_halt;

  assign accept  = issue_valid & issue_ready;
  assign is_halt = (opcode == HALT_OPCODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      imem_en     <= 1'b0;
      imem_addr   <= '0;
      issue_valid <= 1'b0;
      opcode      <= '0;
      imm_flag    <= 1'b0;
      format      <= '0;
      operand     <= '0;
      issue_pc    <= '0;
      halted      <= 1'b0;
    end else begin
      imem_en <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_REQ;
            imem_en   <= 1'b1;
            imem_addr <= pc;
          end
        end
        S_REQ: begin
          if (redirect_valid) begin
            pc        <= redirect_pc;
            imem_en   <= 1'b1;
            imem_addr <= redirect_pc;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // a redirect here drops the returning word
          if (redirect_valid) begin
            state     <= S_REQ;
            pc        <= redirect_pc;
            imem_en   <= 1'b1;
            imem_addr <= redirect_pc;
          end else begin
            state       <= S_ISSUE;
            opcode      <= imem_rdata[INSTR_W-1 -: 4];
            imm_flag    <= imem_rdata[INSTR_W-5];
            format      <= imem_rdata[INSTR_W-6 -: 2];
            operand     <= imem_rdata[INSTR_W-8:0];
            issue_pc    <= pc;
            pc          <= pc + PC_W'(1);
            issue_valid <= 1'b1;
          end
        end
        S_ISSUE: begin
          // an accepted HALT takes priority over a same-cycle redirect
          if (accept && is_halt) begin
            state       <= S_HALTED;
            issue_valid <= 1'b0;
            halted      <= 1'b1;
          end else if (redirect_valid) begin
            state       <= S_REQ;
            issue_valid <= 1'b0;
            pc          <= redirect_pc;
            imem_en     <= 1'b1;
            imem_addr   <= redirect_pc;
          end else if (accept) begin
            state       <= S_REQ;
            issue_valid <= 1'b0;
            imem_en     <= 1'b1;
            imem_addr   <= pc;
          end
        end
        S_HALTED: begin
          state <= S_HALTED;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_issue.sv
// tb_fetch_issue: vector table, directed corner sequences and a
// transaction-level random check of the fetch/issue sequencer.
module tb_fetch_issue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       imem_en;
  logic [7:0] imem_addr;
  logic [8:0] imem_rdata;
  logic       issue_valid;
  logic       issue_ready = 1'b0;
  logic [3:0] opcode;
  logic       imm_flag;
  logic [1:0] format;
  logic [1:0] operand;
  logic [7:0] issue_pc;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic       halted;

  logic [8:0] mem [256];
  int checks = 0;
  int errors = 0;

  localparam logic [8:0] W0 = 9'b0111_1_01_10;
  localparam logic [8:0] W1 = 9'b0010_0_11_01;
  localparam logic [8:0] W2 = 9'b0101_1_10_11;
  localparam logic [8:0] WH = 9'b1110_0_00_00;

  fetch_issue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .opcode         (opcode),
    .imm_flag       (imm_flag),
    .format         (format),
    .operand        (operand),
    .issue_pc       (issue_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // synchronous imem; garbage on cycles without a read
  always @(posedge clk)
    imem_rdata <= imem_en ? mem[imem_addr] : 9'($urandom);

  typedef struct {
    logic       st;
    logic       rdy;
    logic       rv;
    logic [7:0] rpc;
    logic       en;
    logic [7:0] addr;
    logic       vld;
    logic [7:0] ipc;
    logic [8:0] word;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic rdy, logic rv,
                              logic [7:0] rpc, logic en,
                              logic [7:0] addr, logic vld,
                              logic [7:0] ipc, logic [8:0] word);
    vec_t v;
    v.st = st; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.en = en; v.addr = addr; v.vld = vld;
    v.ipc = ipc; v.word = word;
    return v;
  endfunction

  function automatic logic [8:0] fields();
    return {opcode, imm_flag, format, operand};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    issue_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_issue(output logic ok, output logic [7:0] pc,
                            output logic [8:0] w);
    ok = 1'b0;
    pc = 8'h00;
    w = 9'h000;
    for (int i = 0; i < 10; i++) begin
      if (issue_valid) begin
        ok = 1'b1;
        pc = issue_pc;
        w = fields();
        break;
      end
      tick();
    end
    if (ok) tick();
  endtask

  logic       ok;
  logic [7:0] got_pc;
  logic [8:0] got_w;
  logic       found;
  int         en_cnt;
  int         vld_cnt;
  logic [7:0] model_pc;
  logic       stall_prev;
  logic [7:0] hold_pc;
  logic [8:0] hold_w;
  int         accepts;
  logic [8:0] w;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 9'h000;
    mem[0] = W0;
    mem[1] = W1;
    mem[2] = WH;
    mem[8'h20] = W2;

    // ---- reset state
    do_reset();
    chk("reset_outputs",
        {imem_en, imem_addr, issue_valid, issue_pc, fields(), halted},
        '0);

    // ---- per-cycle vectors: latency, stall, redirect in WAIT
    tbl.push_back(mk(0, 0, 1, 8'h55, 0, 8'h00, 0, 8'h00, W0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, W0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, W0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h00, W0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h00, W0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h01, 0, 8'h00, W0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, W0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h01, W1));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h02, 0, 8'h00, W1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, W1));
    tbl.push_back(mk(0, 0, 1, 8'h20, 1, 8'h20, 0, 8'h00, W1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, W1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h20, W2));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 8'h21, 0, 8'h00, W2));

    foreach (tbl[i]) begin
      start = tbl[i].st;
      issue_ready = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_pc = tbl[i].rpc;
      tick();
      chk($sformatf("vec%0d_en", i), imem_en, tbl[i].en);
      if (tbl[i].en)
        chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("vec%0d_valid", i), issue_valid, tbl[i].vld);
      if (tbl[i].vld) begin
        chk($sformatf("vec%0d_pc", i), issue_pc, tbl[i].ipc);
        chk($sformatf("vec%0d_word", i), fields(), tbl[i].word);
      end
      chk($sformatf("vec%0d_halted", i), halted, 0);
    end

    // ---- HALT at address 2, then ignore start/redirect
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    issue_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (issue_valid && opcode == 4'b1110) found = 1'b1;
      else tick();
    end
    chk("halt_reached", found, 1);
    chk("halt_pc", issue_pc, 8'h02);
    chk("halt_not_yet", halted, 0);
    tick();
    chk("halted_set", halted, 1);
    chk("halt_valid_clr", issue_valid, 0);
    en_cnt = 0;
    vld_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      redirect_valid = i[1];
      redirect_pc = 8'(i);
      tick();
      en_cnt += int'(imem_en);
      vld_cnt += int'(issue_valid);
    end
    start = 1'b0;
    redirect_valid = 1'b0;
    chk("halt_no_fetch", en_cnt, 0);
    chk("halt_no_issue", vld_cnt, 0);
    chk("halt_sticky", halted, 1);
    rst_n = 1'b0;
    #1;
    chk("halt_async_clr", halted, 0);

    // ---- PC wrap after redirect to 8'hFF
    mem[8'hFF] = W1;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 8'hFF;
    tick();
    chk("wrap_redir_en", imem_en, 1);
    chk("wrap_redir_addr", imem_addr, 8'hFF);
    redirect_valid = 1'b0;
    issue_ready = 1'b1;
    wait_issue(ok, got_pc, got_w);
    chk("wrap_first_ok", ok, 1);
    chk("wrap_first_pc", got_pc, 8'hFF);
    chk("wrap_first_word", got_w, W1);
    wait_issue(ok, got_pc, got_w);
    chk("wrap_second_ok", ok, 1);
    chk("wrap_second_pc", got_pc, 8'h00);
    chk("wrap_second_word", got_w, W0);

    // ---- async reset in the middle of a WAIT cycle
    chk("mid_req_addr", {imem_en, imem_addr}, {1'b1, 8'h01});
    issue_ready = 1'b0;
    tick();
    chk("mid_wait_idle_outputs", {imem_en, issue_valid}, 0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {imem_en, imem_addr, issue_valid, issue_pc, fields(), halted},
        '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_addr", {imem_en, imem_addr}, {1'b1, 8'h00});

    // ---- random ready/redirect against a transaction-level model
    for (int a = 0; a < 256; a++) begin
      do w = 9'($urandom); while (w[8:5] == 4'b1110);
      mem[a] = w;
    end
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_pc = 8'h00;
    stall_prev = 1'b0;
    hold_pc = 8'h00;
    hold_w = 9'h000;
    accepts = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_en_excl", imem_en & issue_valid, 0);
      if (stall_prev)
        chk("rnd_hold", {issue_valid, issue_pc, fields()},
            {1'b1, hold_pc, hold_w});
      issue_ready = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc = 8'($urandom);
      if (issue_valid && issue_ready) begin
        chk("rnd_pc", issue_pc, model_pc);
        chk("rnd_word", fields(), mem[model_pc]);
        accepts++;
      end
      stall_prev = issue_valid && !issue_ready && !redirect_valid;
      hold_pc = issue_pc;
      hold_w = fields();
      if (redirect_valid) model_pc = redirect_pc;
      else if (issue_valid && issue_ready) model_pc = model_pc + 8'd1;
      tick();
    end
    issue_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("rnd_progress", accepts > 200, 1);
    chk("rnd_not_halted", halted, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
